excpt_sequencer: RTL

// - Multicycle FSM that handles CPU exceptions: invalid opcode, ALU overflow, divide-by-zero.
// - Latches the cause, saves EPC and drives the exception-vector mux select.
// - Reads the handler byte from memory at 253/254/255 and loads it, zero-extended, into PC.
// - Sits beside the main control unit; asserts busy so main control freezes while it runs.

---
 rtl/cpu_defs.sv | 67 ++++++
 rtl/excpt_sequencer.sv | 126 ++++++++++++
 2 files changed

// File: rtl/cpu_defs.sv
// Shared CPU definitions used by the exception sequencer: state encoding,
// cause codes, exception vector addresses and vector-mux select encodings.
package cpu_defs;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned CTRL_W  = 3;
    localparam int unsigned CAUSE_W = 2;
    localparam int unsigned CNT_W   = 3;
    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 3'd0,
        SAVE = 3'd1,
        RD   = 3'd2,
        WAIT = 3'd3,
        LOAD = 3'd4
    } excpt_state_e;

    typedef enum logic [CAUSE_W-1:0] {
        CAUSE_NONE   = 2'b00,
        CAUSE_OPCODE = 2'b01,
        CAUSE_OVF    = 2'b10,
        CAUSE_DIV0   = 2'b11
    } cause_e;

    // Handler-byte addresses in memory
    localparam logic [BYTE_W-1:0] VEC_OPCODE = 8'd253;
    localparam logic [BYTE_W-1:0] VEC_OVF    = 8'd254;
    localparam logic [BYTE_W-1:0] VEC_DIV0   = 8'd255;

    // Vector-mux select; bit 0 is a don't-care once bit 1 picks the div0 vector
    localparam logic [CTRL_W-1:0] CTRL_OPCODE = 3'b000;
    localparam logic [CTRL_W-1:0] CTRL_OVF    = 3'b001;
    localparam logic [CTRL_W-1:0] CTRL_DIV0   = 3'b010;

    // Same-cycle events resolve opcode > ovf > div0
    function automatic cause_e pick_cause(input logic opcode, input logic ovf, input logic div0);
        if (opcode) begin
            return CAUSE_OPCODE;
        end else if (ovf) begin
            return CAUSE_OVF;
        end else if (div0) begin
            return CAUSE_DIV0;
        end
        return CAUSE_NONE;
    endfunction

    function automatic logic [CTRL_W-1:0] cause_ctrl(input cause_e c);
        case (c)
            CAUSE_OVF:  return CTRL_OVF;
            CAUSE_DIV0: return CTRL_DIV0;
            default:    return CTRL_OPCODE;
        endcase
    endfunction

    // Address the vector mux presents for a given select
    function automatic logic [BYTE_W-1:0] ctrl_vector(input logic [CTRL_W-1:0] ctrl);
        if (ctrl[1]) begin
            return VEC_DIV0;
        end else if (ctrl[0]) begin
            return VEC_OVF;
        end
        return VEC_OPCODE;
    endfunction

endpackage

// File: rtl/excpt_sequencer.sv
// Multicycle exception sequencer: latches the cause, saves EPC, fetches the
// handler byte through the vector mux and loads it into PC while holding busy.
module excpt_sequencer
    import cpu_defs::*;
#(
    parameter int unsigned MEM_LAT = 2,
    parameter int unsigned PC_ADJ  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                excp_opcode,
    input  logic                excp_ovf,
    input  logic                excp_div0,
    input  logic [XLEN-1:0]     pc_in,
    input  logic [BYTE_W-1:0]   mem_rdata,
    output logic                busy,
    output logic [CTRL_W-1:0]   excpt_ctrl,
    output logic                addr_sel,
    output logic                mem_rd,
    output logic                epc_we,
    output logic [XLEN-1:0]     epc_data,
    output logic                pc_we,
    output logic [XLEN-1:0]     pc_data,
    output logic [CAUSE_W-1:0]  cause
);

    excpt_state_e        state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                any_evt;
    cause_e              evt_cause;

    logic                busy_d, addr_sel_d, mem_rd_d, epc_we_d, pc_we_d;
    logic [CTRL_W-1:0]   ctrl_d;
    logic [CAUSE_W-1:0]  cause_d;
    logic [XLEN-1:0]     epc_data_d, pc_data_d;

    // Outputs are registered alongside the state, so each is computed for the state being entered
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ctrl_d     = excpt_ctrl;
        cause_d    = cause;
        busy_d     = 1'b0;
        addr_sel_d = 1'b0;
        mem_rd_d   = 1'b0;
        epc_we_d   = 1'b0;
        pc_we_d    = 1'b0;
        epc_data_d = '0;
        pc_data_d  = '0;
        any_evt    = excp_opcode | excp_ovf | excp_div0;
        evt_cause  = pick_cause(excp_opcode, excp_ovf, excp_div0);

        unique case (state_q)
            IDLE: begin
                if (any_evt) begin
                    state_d    = SAVE;
                    cause_d    = evt_cause;
                    ctrl_d     = cause_ctrl(evt_cause);
                    busy_d     = 1'b1;
                    epc_we_d   = 1'b1;
                    epc_data_d = pc_in - XLEN'(PC_ADJ);
                end
            end
            SAVE: begin
                state_d    = RD;
                busy_d     = 1'b1;
                addr_sel_d = 1'b1;
                mem_rd_d   = 1'b1;
            end
            RD: begin
                state_d    = WAIT;
                cnt_d      = CNT_W'(MEM_LAT - 1);
                busy_d     = 1'b1;
                addr_sel_d = 1'b1;
            end
            WAIT: begin
                busy_d = 1'b1;
                if (cnt_q == '0) begin
                    state_d   = LOAD;
                    pc_we_d   = 1'b1;
                    pc_data_d = XLEN'(mem_rdata);
                end else begin
                    cnt_d      = cnt_q - CNT_W'(1);
                    addr_sel_d = 1'b1;
                end
            end
            LOAD: begin
                // Events arriving here are dropped; only IDLE accepts them
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter and registered outputs; reset aborts any sequence in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            busy       <= 1'b0;
            excpt_ctrl <= '0;
            addr_sel   <= 1'b0;
            mem_rd     <= 1'b0;
            epc_we     <= 1'b0;
            epc_data   <= '0;
            pc_we      <= 1'b0;
            pc_data    <= '0;
            cause      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            busy       <= busy_d;
            excpt_ctrl <= ctrl_d;
            addr_sel   <= addr_sel_d;
            mem_rd     <= mem_rd_d;
            epc_we     <= epc_we_d;
            epc_data   <= epc_data_d;
            pc_we      <= pc_we_d;
            pc_data    <= pc_data_d;
            cause      <= cause_d;
        end
    end

endmodule
